pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage rv32i pipeline.
- Each cycle it drives the load and sel (bubble-insert) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB control-word and data registers, plus load_pc.
- Arbitrates three hazard sources: memory wait, control redirect and load-use. Tracks the action taken in a small FSM for debug and performance visibility.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 20 ++
 rtl/pipeline_hazard_ctrl_if.sv | 31 +++
 rtl/hazard_perf_counter.sv | 15 +
 rtl/pipeline_hazard_ctrl.sv | 34 +++
 tb/tb_pipeline_hazard_ctrl.sv | 90 +++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared widths, state enum and control-word bundle for the hazard controller
package pipeline_hazard_ctrl_pkg;
    localparam int REG_IDX_W = 5;
    localparam int CNT_W = 32;
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, BUBBLE = 2'd2, FLUSH = 2'd3} hz_state_t;
    typedef struct packed {
        logic load_pc;
        logic load_if_id;
        logic load_id_ex;
        logic load_ex_mem;
        logic load_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
    } hz_ctrl_t;
    function automatic hz_ctrl_t ctrl_of(hz_state_t s);
        return s == STALL  ? hz_ctrl_t'(7'b0000000) :
               s == FLUSH  ? hz_ctrl_t'(7'b1111111) :
               s == BUBBLE ? hz_ctrl_t'(7'b0011101) : hz_ctrl_t'(7'b1111100);
    endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard sources in, stage load/flush controls out; counters with HAZARD_PERF_CNT_EN
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;
    logic imem_busy, imem_resp, dmem_busy, dmem_resp;
    logic ex_redirect, ex_mem_read, id_uses_rs1, id_uses_rs2;
    logic [REG_IDX_W-1:0] ex_rd, id_rs1, id_rs2;
    logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic flush_if_id, flush_id_ex;
    hz_state_t hz_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;
`endif
    modport master(
        output imem_busy, imem_resp, dmem_busy, dmem_resp, ex_redirect, ex_mem_read,
               ex_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, hz_state
`ifdef HAZARD_PERF_CNT_EN
        , input stall_cnt, bubble_cnt, flush_cnt
`endif
    );
    modport slave(
        input  imem_busy, imem_resp, dmem_busy, dmem_resp, ex_redirect, ex_mem_read,
               ex_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, hz_state
`ifdef HAZARD_PERF_CNT_EN
        , output stall_cnt, bubble_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/hazard_perf_counter.sv
// hazard_perf_counter: saturating event counter, only built with HAZARD_PERF_CNT_EN
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk)
        if (rst) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule
`endif

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/bubble scheduler for the 5-stage rv32i pipeline; perf counters with HAZARD_PERF_CNT_EN
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);
    hz_state_t state, next;
    hz_ctrl_t ctrl;
    logic mem_wait, load_use;
    // redirect outranks load-use: the ID instruction behind a taken branch is wrong-path
    always_comb begin
        mem_wait = (hz.imem_busy & ~hz.imem_resp) | (hz.dmem_busy & ~hz.dmem_resp);
        load_use = hz.ex_mem_read & (hz.ex_rd != '0) &
                   ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) | (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));
        next = mem_wait ? STALL : hz.ex_redirect ? FLUSH : load_use ? BUBBLE : RUN;
        ctrl = rst ? '0 : ctrl_of(next);
    end
    always_ff @(posedge clk) state <= rst ? RUN : next;
    assign hz.load_pc     = ctrl.load_pc;
    assign hz.load_if_id  = ctrl.load_if_id;
    assign hz.load_id_ex  = ctrl.load_id_ex;
    assign hz.load_ex_mem = ctrl.load_ex_mem;
    assign hz.load_mem_wb = ctrl.load_mem_wb;
    assign hz.flush_if_id = ctrl.flush_if_id;
    assign hz.flush_id_ex = ctrl.flush_id_ex;
    assign hz.hz_state    = state;
`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk, .rst, .inc(next == STALL), .cnt(hz.stall_cnt));
    hazard_perf_counter #(.CNT_W(CNT_W)) u_bubble_cnt (.clk, .rst, .inc(next == BUBBLE), .cnt(hz.bubble_cnt));
    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk, .rst, .inc(next == FLUSH), .cnt(hz.flush_cnt));
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed + random scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    pipeline_hazard_ctrl_if hz();
    pipeline_hazard_ctrl dut (.clk(clk), .rst(rst), .hz(hz));
    int vectors = 0;
    int miscompares = 0;
    logic [1:0] exp_q[$];
    logic [CNT_W-1:0] m_stall = '0, m_bubble = '0, m_flush = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // one cycle: drive, check combinational controls, then check registered state after the edge
    task automatic step(input string tag, input logic r, ib, ir, db, dr, red, mr,
                        input logic [4:0] rd, rs1, rs2, input logic u1, u2);
        logic mw, lu;
        logic [6:0] want;
        logic [1:0] act, q;
        rst = r;
        hz.imem_busy = ib; hz.imem_resp = ir; hz.dmem_busy = db; hz.dmem_resp = dr;
        hz.ex_redirect = red; hz.ex_mem_read = mr; hz.ex_rd = rd;
        hz.id_rs1 = rs1; hz.id_rs2 = rs2; hz.id_uses_rs1 = u1; hz.id_uses_rs2 = u2;
        mw = (ib && !ir) || (db && !dr);
        lu = mr && rd != 5'd0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (r)        begin want = 7'b0000000; act = 2'd0; end
        else if (mw)  begin want = 7'b0000000; act = 2'd1; end
        else if (red) begin want = 7'b1111111; act = 2'd3; end
        else if (lu)  begin want = 7'b0011101; act = 2'd2; end
        else          begin want = 7'b1111100; act = 2'd0; end
        exp_q.push_back(act);
        #2;
        check({tag, "/ctrl"}, {25'd0, hz.load_pc, hz.load_if_id, hz.load_id_ex, hz.load_ex_mem,
              hz.load_mem_wb, hz.flush_if_id, hz.flush_id_ex}, {25'd0, want});
        @(posedge clk);
        #1;
        q = exp_q.pop_front();
        check({tag, "/state"}, {30'd0, hz.hz_state}, {30'd0, q});
`ifdef HAZARD_PERF_CNT_EN
        m_stall  = r ? '0 : (!r && act == 2'd1 && !(&m_stall))  ? m_stall + 1  : m_stall;
        m_bubble = r ? '0 : (!r && act == 2'd2 && !(&m_bubble)) ? m_bubble + 1 : m_bubble;
        m_flush  = r ? '0 : (!r && act == 2'd3 && !(&m_flush))  ? m_flush + 1  : m_flush;
        check({tag, "/stall_cnt"}, hz.stall_cnt, m_stall);
        check({tag, "/bubble_cnt"}, hz.bubble_cnt, m_bubble);
        check({tag, "/flush_cnt"}, hz.flush_cnt, m_flush);
`endif
    endtask

    initial begin
        //          tag         r  ib ir db dr red mr rd  rs1 rs2 u1 u2
        step("reset0",          1, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0, 0);
        step("reset1",          1, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0, 0);
        step("idle",            0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0, 0);
        for (int i = 0; i < 4; i++)
            step("dmem_wait",   0, 0, 0, 1, 0, 0,  0, 0,  0,  0,  0, 0);
        step("dmem_resp",       0, 0, 0, 1, 1, 0,  0, 0,  0,  0,  0, 0);
        step("lu_rs1",          0, 0, 0, 0, 0, 0,  1, 5,  5,  3,  1, 0);
        step("lu_after",        0, 0, 0, 0, 0, 0,  0, 5,  5,  3,  1, 0);
        step("lu_rs2",          0, 0, 0, 0, 0, 0,  1, 7,  2,  7,  0, 1);
        step("lu_rs2_unused",   0, 0, 0, 0, 0, 0,  1, 7,  2,  7,  1, 0);
        step("x0_guard",        0, 0, 0, 0, 0, 0,  1, 0,  0,  0,  1, 1);
        for (int i = 0; i < 3; i++)
            step("redir_stall", 0, 1, 0, 0, 0, 1,  0, 0,  0,  0,  0, 0);
        step("redir_apply",     0, 1, 1, 0, 0, 1,  0, 0,  0,  0,  0, 0);
        step("redir_done",      0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0, 0);
        step("redir_vs_lu",     0, 0, 0, 0, 0, 1,  1, 9,  9,  0,  1, 0);
        step("split_resp_a",    0, 1, 1, 1, 0, 0,  0, 0,  0,  0,  0, 0);
        step("split_resp_b",    0, 0, 0, 1, 1, 0,  0, 0,  0,  0,  0, 0);
        step("stall_vs_lu",     0, 0, 0, 1, 0, 0,  1, 4,  4,  0,  1, 0);
        step("pre_rst_stall",   0, 0, 0, 1, 0, 0,  0, 0,  0,  0,  0, 0);
        step("rst_mid_stall",   1, 0, 0, 1, 0, 0,  0, 0,  0,  0,  0, 0);
        step("post_rst_stall",  0, 0, 0, 1, 0, 0,  0, 0,  0,  0,  0, 0);
        step("rst_mid_bubble",  1, 0, 0, 0, 0, 0,  1, 6,  6,  0,  1, 0);
        step("post_rst_bubble", 0, 0, 0, 0, 0, 0,  1, 6,  6,  0,  1, 0);
        for (int i = 0; i < 40; i++)
            step("random", $urandom_range(0, 15) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
